// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder: time-shares one adder_8bit across NUM_BYTES cycles.
// Optional subtract mode is built when ADD_SEQ_SUB_EN is defined.

module adder_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carry_in,
   output logic [7:0] sum,
   output logic       overflow
);
   assign {overflow, sum} = 9'(a) + 9'(b) + 9'(carry_in);
endmodule

module add_seq_ctrl #(
   parameter int unsigned NUM_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [8*NUM_BYTES-1:0] a,
   input  logic [8*NUM_BYTES-1:0] b,
   input  logic                   carry_in,
`ifdef ADD_SEQ_SUB_EN
   input  logic                   sub,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [8*NUM_BYTES-1:0] sum,
   output logic                   overflow
);

   localparam int unsigned W     = 8 * NUM_BYTES;
   localparam int unsigned ACC_W = W - 8;
   localparam int unsigned IDX_W = $clog2(NUM_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               carry_q, carry_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [7:0]         add_sum;
   logic               add_co;
   logic               last_byte;
   logic [W-1:0]       b_load;
   logic               cin_load;

   adder_8bit u_adder (
      .a        (a_q[7:0]),
      .b        (b_q[7:0]),
      .carry_in (carry_q),
      .sum      (add_sum),
      .overflow (add_co)
   );

   assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

   // Operand B / carry as loaded: subtract is a + ~b + 1.
`ifdef ADD_SEQ_SUB_EN
   assign b_load   = sub ? ~b : b;
   assign cin_load = sub ? 1'b1 : carry_in;
`else
   assign b_load   = b;
   assign cin_load = carry_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_ADD;
         S_ADD:   if (last_byte) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; accumulator fills from the MSB end one byte per cycle.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b_load;
               carry_d = cin_load;
               idx_d   = '0;
            end
         end
         S_ADD: begin
            a_d     = {8'h00, a_q[W-1:8]};
            b_d     = {8'h00, b_q[W-1:8]};
            carry_d = add_co;
            acc_d   = ACC_W'({add_sum, acc_q} >> 8);
            idx_d   = idx_q + IDX_W'(1);
            if (last_byte) begin
               sum_d = {add_sum, acc_q};
               ovf_d = add_co;
            end
         end
         default: ;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign overflow = ovf_q;

endmodule
